// File: rtl/lcd_text_writer.sv
// lcd_text_writer: turns key events into single-cycle writes to the two LCD line memories.
// It also tracks the cursor and blanks both lines after reset or on a clear event.
module lcd_text_writer #(
  parameter int COLS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_kind,
  input  logic [7:0] in_char,
  output logic       wr_en,
  output logic       wr_line,
  output logic [5:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       done,
  output logic       cur_line,
  output logic [5:0] cur_col
);
  localparam int CW = $clog2(2 * COLS + 1);
  localparam logic [5:0] LAST = 6'(COLS - 1);
  localparam logic [CW-1:0] NCLR = CW'(2 * COLS);
  localparam logic [CW-1:0] HALF = CW'(COLS);
  localparam logic [8:0] SPACE = 9'h120;
  typedef enum logic [1:0] {IDLE, WRITE, MOVE, CLEAR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, clr_col;
  logic boot, boot_n, pend_line, pend_line_n;
  logic in_ready_n, wr_en_n, wr_line_n, done_n, cur_line_n;
  logic [5:0] pend_col, pend_col_n, wr_addr_n, cur_col_n;
  logic [8:0] wr_data_n;
  logic at_end, at_home, adv_line, ret_line;
  logic [5:0] adv_col, ret_col;
  assign at_end   = cur_col == LAST;
  assign at_home  = !cur_line && cur_col == 6'd0;
  assign adv_line = at_end ? ~cur_line : cur_line;
  assign adv_col  = at_end ? 6'd0 : cur_col + 6'd1;
  assign ret_line = cur_col == 6'd0 ? 1'b0 : cur_line;
  assign ret_col  = cur_col == 6'd0 ? LAST : cur_col - 6'd1;
  assign clr_col  = cnt < HALF ? cnt : cnt - HALF;
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    boot_n      = boot;
    pend_line_n = pend_line;
    pend_col_n  = pend_col;
    in_ready_n  = 1'b0;
    wr_en_n     = 1'b0;
    wr_line_n   = wr_line;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    done_n      = 1'b0;
    cur_line_n  = cur_line;
    cur_col_n   = cur_col;
    case (state)
      IDLE: begin
        in_ready_n = 1'b1;
        if (in_valid) begin
          in_ready_n = 1'b0;
          boot_n     = 1'b0;
          done_n     = in_kind != 2'b11;
          case (in_kind)
            2'b00: begin
              state_n     = WRITE;
              wr_en_n     = 1'b1;
              wr_line_n   = cur_line;
              wr_addr_n   = cur_col;
              wr_data_n   = {1'b1, in_char};
              pend_line_n = adv_line;
              pend_col_n  = adv_col;
            end
            2'b01: begin
              state_n     = at_home ? MOVE : WRITE;
              wr_en_n     = !at_home;
              wr_line_n   = at_home ? wr_line : ret_line;
              wr_addr_n   = at_home ? wr_addr : ret_col;
              wr_data_n   = at_home ? wr_data : SPACE;
              pend_line_n = at_home ? cur_line : ret_line;
              pend_col_n  = at_home ? cur_col : ret_col;
            end
            2'b10: begin
              state_n     = MOVE;
              pend_line_n = ~cur_line;
              pend_col_n  = 6'd0;
            end
            2'b11: begin
              state_n   = CLEAR;
              cnt_n     = CW'(1);
              wr_en_n   = 1'b1;
              wr_line_n = 1'b0;
              wr_addr_n = 6'd0;
              wr_data_n = SPACE;
            end
          endcase
        end
      end
      WRITE, MOVE: begin
        state_n    = IDLE;
        in_ready_n = 1'b1;
        cur_line_n = pend_line;
        cur_col_n  = pend_col;
      end
      CLEAR: begin
        if (cnt == NCLR) begin
          state_n    = IDLE;
          in_ready_n = 1'b1;
          cur_line_n = 1'b0;
          cur_col_n  = 6'd0;
        end else begin
          wr_en_n   = 1'b1;
          wr_line_n = cnt >= HALF;
          wr_addr_n = 6'(clr_col);
          wr_data_n = SPACE;
          // the power-on blanking is not a keyboard event, so it never reports completion
          done_n    = !boot && cnt == NCLR - CW'(1);
          cnt_n     = cnt + CW'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      boot      <= 1'b1;
      pend_line <= 1'b0;
      pend_col  <= 6'd0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_line   <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= SPACE;
      done      <= 1'b0;
      cur_line  <= 1'b0;
      cur_col   <= 6'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      boot      <= boot_n;
      pend_line <= pend_line_n;
      pend_col  <= pend_col_n;
      in_ready  <= in_ready_n;
      wr_en     <= wr_en_n;
      wr_line   <= wr_line_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      done      <= done_n;
      cur_line  <= cur_line_n;
      cur_col   <= cur_col_n;
    end
  end
endmodule

// File: tb/tb_lcd_text_writer.sv
// tb_lcd_text_writer: scoreboard bench; a linear-cursor model predicts every write/done and the in_ready return.
module tb_lcd_text_writer;
  localparam int COLS = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [1:0] in_kind = 2'd0;
  logic [7:0] in_char = 8'd0;
  logic in_ready, wr_en, wr_line, done, cur_line;
  logic [5:0] wr_addr, cur_col;
  logic [8:0] wr_data;

  lcd_text_writer #(.COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_char(in_char), .wr_en(wr_en), .wr_line(wr_line), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .cur_line(cur_line), .cur_col(cur_col)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit we; bit line; int addr; int data; bit dn; int cyc;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int pos = 0, ready_cyc = -1;
  bit fin = 0, stuck = 0, prev_ready = 0;

  // cursor is a single position 0..2*COLS-1 (line = pos/COLS)
  function automatic void push(bit we, int p, int data, bit dn, int c);
    exp_t e;
    e.we = we; e.line = (p >= COLS); e.addr = p % COLS; e.data = data; e.dn = dn; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic void model(int kind, int ch, int c);
    ready_cyc = c + 2;
    case (kind)
      0: begin push(1, pos, 'h100 | ch, 1, c + 1); pos = (pos + 1) % (2 * COLS); end
      1: if (pos == 0) push(0, 0, 0, 1, c + 1);
         else begin pos = pos - 1; push(1, pos, 'h120, 1, c + 1); end
      2: begin push(0, 0, 0, 1, c + 1); pos = (pos < COLS) ? COLS : 0; end
      default: begin
        for (int i = 0; i < 2 * COLS; i++) push(1, i, 'h120, i == 2 * COLS - 1, c + 1 + i);
        pos = 0;
        ready_cyc = c + 2 * COLS + 1;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (wr_en !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || wr_line !== 1'b0 || wr_addr !== 6'd0 ||
          wr_data !== 9'h120 || cur_line !== 1'b0 || cur_col !== 6'd0) begin
        n_bad++;
        $display("FAIL reset_vals cyc=%0d got we=%b dn=%b rdy=%b line=%b addr=%0d data=%h cur=(%b,%0d) want 0/0/0/0/0/120/(0,0)",
                 cyc, wr_en, done, in_ready, wr_line, wr_addr, wr_data, cur_line, cur_col);
      end
    end else begin
      if (wr_en || done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out cyc=%0d got we=%b line=%b addr=%0d data=%h done=%b want nothing",
                   cyc, wr_en, wr_line, wr_addr, wr_data, done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || wr_en !== e.we || done !== e.dn ||
              (e.we && (wr_line !== e.line || int'(wr_addr) != e.addr || int'(wr_data) != e.data))) begin
            n_bad++;
            $display("FAIL out cyc=%0d got we=%b line=%b addr=%0d data=%h done=%b want cyc=%0d we=%b line=%b addr=%0d data=%h done=%b",
                     cyc, wr_en, wr_line, wr_addr, wr_data, done, e.cyc, e.we, e.line, e.addr, e.data, e.dn);
          end
        end
      end
      if (in_ready && !prev_ready) begin
        n_cmp++;
        if (cyc != ready_cyc || cur_line !== (pos >= COLS) || int'(cur_col) != pos % COLS) begin
          n_bad++;
          $display("FAIL ready_cursor got cyc=%0d cur=(%b,%0d) want cyc=%0d cur=(%0d,%0d)",
                   cyc, cur_line, cur_col, ready_cyc, pos / COLS, pos % COLS);
        end
      end
    end
    prev_ready = in_ready;
    if (fin) begin
      n_cmp++;
      if (stuck || exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain got %0d pending stuck=%b want 0 pending stuck=0", exp_q.size(), stuck);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic give_up(string what);
    $display("FAIL timeout %s at cyc=%0d", what, cyc);
    stuck = 1; fin = 1;
    forever @(negedge clk);
  endtask

  // all driver tasks start and end at negedge+1
  task automatic send(int kind, int ch, bit hold);
    int n = 0;
    in_valid = 1'b1; in_kind = 2'(kind); in_char = 8'(ch);
    while (!in_ready) begin
      @(negedge clk); #1;
      if (++n > 200) give_up("send");
    end
    model(kind, ch, cyc);
    @(posedge clk); #1;
    in_kind = 2'($urandom); in_char = 8'($urandom);
    if (!hold) in_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready) begin
      @(negedge clk); #1;
      if (++n > 200) give_up("idle");
    end
  endtask

  task automatic release_rst();
    rst = 1'b1;
    for (int i = 0; i < 2 * COLS; i++) push(1, i, 'h120, 0, cyc + 1 + i);
    pos = 0;
    ready_cyc = cyc + 2 * COLS + 1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 release_rst();
    for (int i = 0; i < 17; i++) send(0, 'h41, i != 16);
    for (int i = 0; i < 14; i++) send(0, 'h78, 0);
    send(0, 'h5A, 0);
    send(0, 'h42, 0);
    send(2, 0, 0);
    send(1, 0, 0);
    send(2, 0, 0);
    send(2, 0, 0);
    send(1, 0, 1);
    for (int i = 0; i < 7; i++) send(0, 'h30 + i, 1);
    send(2, 0, 1);
    send(2, 0, 0);
    for (int i = 0; i < 50; i++) begin
      int r = int'($urandom_range(0, 9));
      send(r < 6 ? 0 : r < 8 ? 1 : r == 8 ? 2 : 3, int'($urandom_range(32, 126)), 1'($urandom));
    end
    wait_idle();
    if (pos >= COLS) send(2, 0, 0);
    for (int i = 0; i < 5; i++) send(0, 'h61 + i, 0);
    send(3, 0, 0);
    repeat (9) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 release_rst();
    send(0, 'h43, 1);
    send(1, 0, 1);
    send(1, 0, 0);
    wait_idle();
    fin = 1;
  end
endmodule
